// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC and issues it to fetch with a valid/ready handshake.
// Latency: pc, redirected and misalign_err are registered (one cycle after the causing request); pc_seq is combinational.
// Backpressure: pc holds while fetch_ready=0 unless a redirect arrives. PC_MISALIGN_TRAP_EN enables the misaligned-redirect check.
module pc_gen #(
  parameter int                  WIDTH_PC     = 32,
  parameter logic [WIDTH_PC-1:0] RESET_VECTOR = '0,
  parameter int                  STEP         = 4,
  parameter int                  BOOT_CYCLES  = 2,
  parameter int                  ALIGN_BITS   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trap_en,
  input  logic [WIDTH_PC-1:0] trap_target,
  input  logic                br_en,
  input  logic [WIDTH_PC-1:0] br_target,
  input  logic                halt_req,
  input  logic                resume,
  input  logic                fetch_ready,
  output logic                fetch_valid,
  output logic [WIDTH_PC-1:0] pc,
  output logic [WIDTH_PC-1:0] pc_seq,
  output logic                redirected,
  output logic                halted,
  output logic                misalign_err
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam int CNT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
  localparam logic [CNT_W-1:0]    BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [WIDTH_PC-1:0] ALIGN_MASK = WIDTH_PC'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [WIDTH_PC-1:0] STEP_W     = WIDTH_PC'(STEP);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic CHECK_ALIGN = 1'b1;
`else
  localparam logic CHECK_ALIGN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    boot_cnt_q;
  logic                halt_pend_q;
  logic [WIDTH_PC-1:0] pc_q;
  logic                redirected_q;

  logic                redir_req;
  logic [WIDTH_PC-1:0] redir_tgt;
  logic                redir_bad;
  logic                redir_take;
  logic                fire;
  logic                boot_done;

  // Trap has priority; a rejected trap still blocks the branch because the trap target stays selected.
  assign redir_req  = trap_en | br_en;
  assign redir_tgt  = trap_en ? trap_target : br_target;
  assign redir_bad  = CHECK_ALIGN & (|(redir_tgt & ALIGN_MASK));
  assign redir_take = redir_req & ~redir_bad;
  assign fire       = fetch_valid & fetch_ready;
  assign boot_done  = (boot_cnt_q == BOOT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a halt requested during boot skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: begin
        if (boot_done) begin
          state_d = (halt_pend_q | halt_req) ? S_HALT : S_RUN;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (resume && !halt_req) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    fetch_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_RUN:   fetch_valid = 1'b1;
      S_HALT:  halted      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt_q  <= '0;
      halt_pend_q <= 1'b0;
    end else if (state_q == S_BOOT) begin
      boot_cnt_q  <= boot_cnt_q + CNT_W'(1);
      halt_pend_q <= halt_pend_q | halt_req;
    end else begin
      boot_cnt_q  <= '0;
      halt_pend_q <= 1'b0;
    end
  end

  // PC update: redirects apply in every state; sequential advance only on an accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      redirected_q <= 1'b0;
    end else begin
      redirected_q <= redir_take;
      if (redir_take) begin
        pc_q <= redir_tgt;
      end else if (!redir_req && fire) begin
        pc_q <= pc_q + STEP_W;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redir_req & redir_bad;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign pc         = pc_q;
  assign pc_seq     = pc_q + STEP_W;
  assign redirected = redirected_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expectations are queued as each step is driven and compared after the edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_en, br_en, halt_req, resume, fetch_ready;
  logic [31:0] trap_target, br_target;
  logic        fetch_valid, redirected, halted, misalign_err;
  logic [31:0] pc, pc_seq;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        red;
    logic        hlt;
    logic        merr;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  pc_gen #(
    .WIDTH_PC    (32),
    .RESET_VECTOR(32'h0000_0000),
    .STEP        (4),
    .BOOT_CYCLES (2),
    .ALIGN_BITS  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trap_en     (trap_en),
    .trap_target (trap_target),
    .br_en       (br_en),
    .br_target   (br_target),
    .halt_req    (halt_req),
    .resume      (resume),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .pc          (pc),
    .pc_seq      (pc_seq),
    .redirected  (redirected),
    .halted      (halted),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".pc"},     pc,                    e.pc);
    chk({e.tag, ".pc_seq"}, pc_seq,                e.pc + 32'd4);
    chk({e.tag, ".valid"},  {31'd0, fetch_valid},  {31'd0, e.fv});
    chk({e.tag, ".redir"},  {31'd0, redirected},   {31'd0, e.red});
    chk({e.tag, ".halted"}, {31'd0, halted},       {31'd0, e.hlt});
    chk({e.tag, ".merr"},   {31'd0, misalign_err}, {31'd0, e.merr});
  endtask

  task automatic set_in(input logic te, input logic [31:0] tt, input logic be, input logic [31:0] bt,
                        input logic hr, input logic rs, input logic rdy);
    trap_en = te; trap_target = tt; br_en = be; br_target = bt;
    halt_req = hr; resume = rs; fetch_ready = rdy;
  endtask

  task automatic run(input logic rdy);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, rdy);
  endtask

  // Queue the expected post-edge state, clock once, then compare #1 after the edge.
  task automatic step(input string tag, input logic [31:0] e_pc, input logic e_fv, input logic e_red,
                      input logic e_hlt, input logic e_merr);
    exp_t e;
    e.pc = e_pc; e.fv = e_fv; e.red = e_red; e.hlt = e_hlt; e.merr = e_merr; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic check_now(input string tag, input logic [31:0] e_pc, input logic e_fv, input logic e_red,
                           input logic e_hlt, input logic e_merr);
    exp_t e;
    e.pc = e_pc; e.fv = e_fv; e.red = e_red; e.hlt = e_hlt; e.merr = e_merr; e.tag = tag;
    sb.push_back(e);
    compare_head();
  endtask

  initial begin
    rst_n = 1'b0;
    run(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Boot takes two cycles, then sequential fetch
    step("boot1", 32'h0,  1'b0, 1'b0, 1'b0, 1'b0);
    step("boot2", 32'h0,  1'b1, 1'b0, 1'b0, 1'b0);
    step("seq4",  32'h4,  1'b1, 1'b0, 1'b0, 1'b0);
    step("seq8",  32'h8,  1'b1, 1'b0, 1'b0, 1'b0);
    step("seqC",  32'hC,  1'b1, 1'b0, 1'b0, 1'b0);
    step("seq10", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure at 0x10
    run(1'b0);
    step("stall1", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("stall2", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("stall3", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b1);
    step("unstall", 32'h14, 1'b1, 1'b0, 1'b0, 1'b0);
    step("seq18",   32'h18, 1'b1, 1'b0, 1'b0, 1'b0);
    step("seq1C",   32'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    step("seq20",   32'h20, 1'b1, 1'b0, 1'b0, 1'b0);

    // Trap beats branch
    set_in(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    step("trap", 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    run(1'b1);
    step("post_trap", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);

    // Halt with a same-cycle handshake, branch while halted, resume
    set_in(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    step("br40", 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step("halt", 32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    run(1'b1);
    step("halt_hold", 32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    step("halt_br", 32'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step("halt_and_resume", 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step("resume", 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b1);
    step("post_resume", 32'h84, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wraparound
    set_in(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    step("br_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
    run(1'b1);
    step("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Misaligned targets
    set_in(1'b0, 32'h0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
    step("br30", 32'h30, 1'b1, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b0, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
    step("br_misaligned", 32'h30, 1'b1, 1'b0, 1'b0, 1'b1);
    run(1'b1);
    step("after_reject", 32'h34, 1'b1, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 32'h101, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    step("trap_misaligned", 32'h34, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    step("br_misaligned", 32'h102, 1'b1, 1'b1, 1'b0, 1'b0);
    run(1'b1);
    step("after_unaligned", 32'h106, 1'b1, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 32'h101, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    step("trap_unaligned", 32'h101, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Reset mid-operation clears a live pulse immediately
    run(1'b1);
    set_in(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    step("br500", 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("mid_reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Halt requested during boot goes straight to HALT
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step("boot_halt1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b1);
    step("boot_halt2", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step("boot_resume", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b1);
    step("boot_seq4", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
